// File: rtl/usb_tx_pkg.sv
// Shared types and width constants for the USB transmit scheduler.
package usb_tx_pkg;

  localparam int PKT_W_DEFAULT = 99;
  localparam int IPG_W         = 4;
  localparam int TO_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_SEND      = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

endpackage

// File: rtl/usb_rr_arb.sv
// Combinational one-hot arbiter: round-robin from ptr, or fixed priority
// (index 0 first) when USB_TX_SCHED_FIXED_PRIO_EN is defined.
module usb_rr_arb #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

  logic found_s;

`ifdef USB_TX_SCHED_FIXED_PRIO_EN
  logic ptr_unused_s;
  assign ptr_unused_s = ^ptr;

  // Lowest set index wins
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i]  = req[i] & ~found_s;
      found_s = found_s | req[i];
    end
  end
`else
  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] idx_s;

  // Scan from ptr upward, wrapping at N_REQ; first set request wins
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s      = {1'b0, ptr} + (PTR_W+1)'(k);
      idx_s      = (sum_s >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum_s - (PTR_W+1)'(N_REQ))
                                                : sum_s[PTR_W-1:0];
      gnt[idx_s] = req[idx_s] & ~found_s;
      found_s    = found_s | req[idx_s];
    end
  end
`endif

endmodule

// File: rtl/usb_tx_sched.sv
// Serialises packets from N_REQ sources onto the shared USB TX encoder.
// Build option: USB_TX_SCHED_FIXED_PRIO_EN selects fixed priority arbitration.
module usb_tx_sched
  import usb_tx_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int PKT_W      = PKT_W_DEFAULT,
  parameter int IPG_CYCLES = 2,
  parameter int START_TO   = 8
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PKT_W-1:0] pkt_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic [PKT_W-1:0]       enc_pkt,
  output logic                   enc_start,
  input  logic                   enc_busy,
  output logic                   sched_idle
);

  localparam int             PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TO_W:0]  TO_LIM  = (TO_W+1)'(START_TO);
  localparam logic [IPG_W:0] IPG_LIM = (IPG_W+1)'(IPG_CYCLES);

  sched_state_e     state_r, state_nxt_s;
  logic [N_REQ-1:0] gnt_r, gnt_nxt_s;
  logic [N_REQ-1:0] done_r, done_nxt_s;
  logic [N_REQ-1:0] err_r, err_nxt_s;
  logic [PKT_W-1:0] enc_pkt_r, enc_pkt_nxt_s;
  logic             enc_start_r, enc_start_nxt_s;
  logic             sched_idle_r, sched_idle_nxt_s;
  logic [TO_W-1:0]  tmo_cnt_r, tmo_cnt_nxt_s;
  logic [IPG_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic [TO_W:0]    tmo_inc_s;
  logic [IPG_W:0]   gap_inc_s;
  logic [N_REQ-1:0] arb_gnt_s;
  logic [PKT_W-1:0] sel_pkt_s;
  logic [PTR_W-1:0] arb_ptr_s;
  logic             gap_entry_s;

  usb_rr_arb #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req (req),
    .ptr (arb_ptr_s),
    .gnt (arb_gnt_s)
  );

  // Select the winning requester's packet slice
  always_comb begin
    sel_pkt_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_pkt_s = sel_pkt_s | (pkt_in[i*PKT_W +: PKT_W] & {PKT_W{arb_gnt_s[i]}});
    end
  end

  assign tmo_inc_s = {1'b0, tmo_cnt_r} + (TO_W+1)'(1);
  assign gap_inc_s = {1'b0, gap_cnt_r} + (IPG_W+1)'(1);

`ifdef USB_TX_SCHED_FIXED_PRIO_EN
  logic gap_entry_unused_s;
  assign gap_entry_unused_s = gap_entry_s;
  assign arb_ptr_s          = '0;
`else
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_adv_s;

  // One past the current winner; the last index wraps to 0
  always_comb begin
    ptr_adv_s = '0;
    for (int i = 0; i < N_REQ-1; i++) begin
      ptr_adv_s = ptr_adv_s | (PTR_W'(i + 1) & {PTR_W{gnt_r[i]}});
    end
  end

  // Round-robin pointer, advanced as the transfer leaves for GAP
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr_r <= '0;
    end else if (gap_entry_s) begin
      ptr_r <= ptr_adv_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign arb_ptr_s = ptr_r;
`endif

  // Next state and next values of all registered outputs
  always_comb begin
    state_nxt_s     = state_r;
    gnt_nxt_s       = gnt_r;
    done_nxt_s      = '0;
    err_nxt_s       = '0;
    enc_pkt_nxt_s   = enc_pkt_r;
    enc_start_nxt_s = 1'b0;
    tmo_cnt_nxt_s   = tmo_cnt_r;
    gap_cnt_nxt_s   = gap_cnt_r;
    gap_entry_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          gnt_nxt_s       = arb_gnt_s;
          enc_pkt_nxt_s   = sel_pkt_s;
          enc_start_nxt_s = 1'b1;
          state_nxt_s     = ST_LOAD;
        end else begin
          gnt_nxt_s = '0;
        end
      end
      ST_LOAD: begin
        tmo_cnt_nxt_s = '0;
        state_nxt_s   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (enc_busy) begin
          state_nxt_s = ST_SEND;
        end else if (tmo_inc_s >= TO_LIM) begin
          err_nxt_s     = gnt_r;
          gnt_nxt_s     = '0;
          gap_cnt_nxt_s = '0;
          gap_entry_s   = 1'b1;
          state_nxt_s   = ST_GAP;
        end else begin
          tmo_cnt_nxt_s = tmo_inc_s[TO_W] ? tmo_cnt_r : tmo_inc_s[TO_W-1:0];
        end
      end
      ST_SEND: begin
        if (!enc_busy) begin
          done_nxt_s    = gnt_r;
          gnt_nxt_s     = '0;
          gap_cnt_nxt_s = '0;
          gap_entry_s   = 1'b1;
          state_nxt_s   = ST_GAP;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_GAP: begin
        // A zero gap still spends this one cycle in GAP
        if (gap_inc_s >= IPG_LIM) begin
          state_nxt_s = ST_IDLE;
        end else begin
          gap_cnt_nxt_s = gap_inc_s[IPG_W] ? gap_cnt_r : gap_inc_s[IPG_W-1:0];
        end
      end
      default: begin
        gnt_nxt_s   = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign sched_idle_nxt_s = (state_nxt_s == ST_IDLE);

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r      <= ST_IDLE;
      gnt_r        <= '0;
      done_r       <= '0;
      err_r        <= '0;
      enc_pkt_r    <= '0;
      enc_start_r  <= 1'b0;
      sched_idle_r <= 1'b1;
      tmo_cnt_r    <= '0;
      gap_cnt_r    <= '0;
    end else begin
      state_r      <= state_nxt_s;
      gnt_r        <= gnt_nxt_s;
      done_r       <= done_nxt_s;
      err_r        <= err_nxt_s;
      enc_pkt_r    <= enc_pkt_nxt_s;
      enc_start_r  <= enc_start_nxt_s;
      sched_idle_r <= sched_idle_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
      gap_cnt_r    <= gap_cnt_nxt_s;
    end
  end

  assign gnt        = gnt_r;
  assign done       = done_r;
  assign err        = err_r;
  assign enc_pkt    = enc_pkt_r;
  assign enc_start  = enc_start_r;
  assign sched_idle = sched_idle_r;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Scoreboard bench for usb_tx_sched: stimulus pushes expected grants, packets
// and done/err pulses; a negedge monitor pops and compares them.
module tb_usb_tx_sched;

  localparam int N = 3;
  localparam int W = 99;

  typedef struct {
    bit           is_err;
    logic [N-1:0] vec;
    int           lat;
  } resp_t;

  logic           clk = 1'b0;
  logic           rst_b = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] pkt_in = '0;
  logic           enc_busy = 1'b0;
  logic [N-1:0]   gnt, done, err;
  logic [W-1:0]   enc_pkt;
  logic           enc_start, sched_idle;

  logic [W-1:0]   pkt_v [N];
  logic [N-1:0]   gnt_q [$];
  logic [W-1:0]   pkt_q [$];
  resp_t          resp_q [$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [N-1:0] m_gnt_prev;
  int           m_zero_run;
  bit           m_seen_gnt;
  logic         m_start_prev;
  int           m_start_cyc;
  resp_t        m_r;

  usb_tx_sched dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req        (req),
    .pkt_in     (pkt_in),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .enc_pkt    (enc_pkt),
    .enc_start  (enc_start),
    .enc_busy   (enc_busy),
    .sched_idle (sched_idle)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_xfer(input int idx, input bit is_err, input int lat, input bit with_resp);
    logic [N-1:0] oh;
    resp_t r;
    oh = '0;
    oh[idx] = 1'b1;
    gnt_q.push_back(oh);
    pkt_q.push_back(pkt_v[idx]);
    r.is_err = is_err;
    r.vec    = oh;
    r.lat    = lat;
    if (with_resp) resp_q.push_back(r);
  endtask

  // Encoder model: after enc_start, idle dly cycles then busy for len cycles
  task automatic enc_xfer(input int dly, input int len);
    int t;
    t = 0;
    while (enc_start !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("start_seen", 128'(t < 200), 128'(1));
    @(posedge clk);
    #1;
    repeat (dly) begin
      @(posedge clk);
      #1;
    end
    if (len > 0) begin
      enc_busy = 1'b1;
      repeat (len) begin
        @(posedge clk);
        #1;
      end
      enc_busy = 1'b0;
    end
  endtask

  task automatic wait_resp();
    int t;
    t = 0;
    while ((done | err) == '0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("resp_seen", 128'(t < 300), 128'(1));
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant, start or pulse
  initial begin
    m_gnt_prev   = '0;
    m_zero_run   = 0;
    m_seen_gnt   = 1'b0;
    m_start_prev = 1'b0;
    m_start_cyc  = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        m_gnt_prev   = '0;
        m_zero_run   = 0;
        m_seen_gnt   = 1'b0;
        m_start_prev = 1'b0;
      end else begin
        if (gnt != '0 && m_gnt_prev == '0) begin
          if (gnt_q.size() == 0) chk("gnt_unexpected", 128'(gnt), 128'(0));
          else chk("gnt", 128'(gnt), 128'(gnt_q.pop_front()));
          if (m_seen_gnt) chk("ipg_idle_cycles", 128'(m_zero_run >= 2), 128'(1));
          m_seen_gnt = 1'b1;
          m_zero_run = 0;
        end else if (gnt == '0) begin
          m_zero_run++;
        end
        if (enc_start) begin
          chk("start_one_cycle", 128'(m_start_prev), 128'(0));
          if (pkt_q.size() == 0) chk("start_unexpected", 128'(enc_start), 128'(0));
          else chk("enc_pkt", 128'(enc_pkt), 128'(pkt_q.pop_front()));
          m_start_cyc = cyc;
        end
        if ((done | err) != '0) begin
          chk("done_err_excl", 128'((done != '0) && (err != '0)), 128'(0));
          if (resp_q.size() == 0) begin
            chk("resp_unexpected", 128'({done, err}), 128'(0));
          end else begin
            m_r = resp_q.pop_front();
            chk(m_r.is_err ? "err_vec" : "done_vec", 128'(m_r.is_err ? err : done), 128'(m_r.vec));
            chk("other_vec", 128'(m_r.is_err ? done : err), 128'(0));
            if (m_r.lat > 0) chk("err_latency", 128'(cyc - m_start_cyc), 128'(m_r.lat));
            chk("gnt_at_resp", 128'(gnt), 128'(0));
          end
        end
        m_start_prev = enc_start;
        m_gnt_prev   = gnt;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_v[0] = 99'h0C3;
    pkt_v[1] = 99'h5A5;
    pkt_v[2] = 99'h7_1234_5678_9ABC_DEF0_1234_5678;
    for (int i = 0; i < N; i++) pkt_in[i*W +: W] = pkt_v[i];

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_gnt", 128'(gnt), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_enc_start", 128'(enc_start), 128'(0));
    chk("rst_enc_pkt", 128'(enc_pkt), 128'(0));
    chk("rst_sched_idle", 128'(sched_idle), 128'(1));
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Single request from source 1, 35-cycle busy, then 2-cycle gap
    expect_xfer(1, 1'b0, 0, 1'b1);
    req = 3'b010;
    @(negedge clk);
    chk("single_gnt_next_cycle", 128'(gnt), 128'(3'b010));
    chk("single_start", 128'(enc_start), 128'(1));
    chk("single_not_idle", 128'(sched_idle), 128'(0));
    enc_xfer(0, 35);
    wait_resp();
    req = '0;
    chk("single_gnt_cleared", 128'(gnt), 128'(0));
    @(negedge clk);
    chk("gap_cycle2_busy", 128'(sched_idle), 128'(0));
    @(negedge clk);
    chk("gap_then_idle", 128'(sched_idle), 128'(1));
    repeat (3) @(negedge clk);

    // Start timeout: encoder never goes busy
    expect_xfer(0, 1'b1, 9, 1'b1);
    req = 3'b001;
    enc_xfer(0, 0);
    wait_resp();
    req = '0;
    repeat (5) @(negedge clk);

    // req[0] drops mid-SEND; done still pulses
    expect_xfer(0, 1'b0, 0, 1'b1);
    req = 3'b001;
    fork
      enc_xfer(1, 6);
      begin
        repeat (5) @(negedge clk);
        req = '0;
      end
    join
    wait_resp();
    repeat (5) @(negedge clk);

    // Reset mid-SEND, then contention from a cleared pointer
    expect_xfer(2, 1'b0, 0, 1'b0);
    req = 3'b100;
    enc_xfer(0, 0);
    enc_busy = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    chk("midrst_gnt", 128'(gnt), 128'(0));
    chk("midrst_enc_start", 128'(enc_start), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_sched_idle", 128'(sched_idle), 128'(1));
    enc_busy = 1'b0;
    req = 3'b111;
`ifdef USB_TX_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) expect_xfer(0, 1'b0, 0, 1'b1);
`else
    expect_xfer(0, 1'b0, 0, 1'b1);
    expect_xfer(1, 1'b0, 0, 1'b1);
    expect_xfer(2, 1'b0, 0, 1'b1);
    expect_xfer(0, 1'b0, 0, 1'b1);
`endif
    repeat (2) @(posedge clk);
    #2;
    rst_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      enc_xfer(0, 3 + k);
      wait_resp();
    end
    req = '0;
    repeat (6) @(negedge clk);

    chk("gnt_q_drained", 128'(gnt_q.size()), 128'(0));
    chk("pkt_q_drained", 128'(pkt_q.size()), 128'(0));
    chk("resp_q_drained", 128'(resp_q.size()), 128'(0));
    chk("final_idle", 128'(sched_idle), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
